// File: rtl/bin16_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock).
// Feeds ready-made BCD digits to the 7-segment multiplexer and flags
// values that do not fit on the physically displayed digits.
module bin16_to_bcd_seq #(
  parameter int IN_WIDTH    = 16,
  parameter int DIGITS      = 5,
  parameter int DISP_DIGITS = 4
) (
  input  logic                  clock_100Mhz,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_WIDTH-1:0]   bin_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  bcd_valid,
  output logic                  overflow,
  output logic                  busy
);

  localparam int W  = 4*DIGITS + IN_WIDTH;
  localparam int CW = $clog2(IN_WIDTH + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [W-1:0]        work_q, work_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                ovf_q, ovf_d;
  logic                valid_q, valid_d;

  // Working register after the add-3 correction and the left shift.
  logic [4*DIGITS-1:0] corr;
  logic [W-1:0]        pre_shift;
  logic [W-1:0]        shifted;
  logic                ovf_calc;

  // Every digit is corrected from its pre-correction value, in parallel.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_corr
      logic [3:0] dig;
      assign dig = work_q[IN_WIDTH + 4*gi +: 4];
      assign corr[4*gi +: 4] = (dig >= 4'd5) ? (dig + 4'd3) : dig;
    end
  endgenerate

  assign pre_shift = {corr, work_q[IN_WIDTH-1:0]};
  assign shifted   = pre_shift << 1;

  // Any non-zero digit above the displayed ones means the value cannot be shown.
  always_comb begin
    ovf_calc = 1'b0;
    for (int k = DISP_DIGITS; k < DIGITS; k++) begin
      ovf_calc = ovf_calc | (|shifted[IN_WIDTH + 4*k +: 4]);
    end
  end

  // Next-state and output decode for the IDLE/SHIFT controller.
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    bcd_d    = bcd_q;
    ovf_d    = ovf_q;
    valid_d  = 1'b0;
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d  = {{(4*DIGITS){1'b0}}, bin_in};
          cnt_d   = CW'(IN_WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy   = 1'b1;
        work_d = shifted;
        cnt_d  = cnt_q - CW'(1);
        // Last shift: publish the finished BCD field directly from the shifter.
        if (cnt_q == CW'(1)) begin
          bcd_d   = shifted[W-1:IN_WIDTH];
          ovf_d   = ovf_calc;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any conversion immediately.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign bcd_out   = bcd_q;
  assign overflow  = ovf_q;
  assign bcd_valid = valid_q;

endmodule

// File: tb/tb_bin16_to_bcd_seq.sv
// Directed self-checking bench for bin16_to_bcd_seq.
module tb_bin16_to_bcd_seq;

  logic        clock_100Mhz;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] bin_in;
  logic [19:0] bcd_out;
  logic        bcd_valid;
  logic        overflow;
  logic        busy;

  int n_cmp;
  int n_fail;
  logic [19:0] last_bcd;

  bin16_to_bcd_seq #(
    .IN_WIDTH(16),
    .DIGITS(5),
    .DISP_DIGITS(4)
  ) dut (
    .clock_100Mhz(clock_100Mhz),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .bin_in(bin_in),
    .bcd_out(bcd_out),
    .bcd_valid(bcd_valid),
    .overflow(overflow),
    .busy(busy)
  );

  initial clock_100Mhz = 1'b0;
  always #5 clock_100Mhz = ~clock_100Mhz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits by divide/modulo.
  function automatic logic [19:0] to_bcd(input int value);
    logic [19:0] r;
    int v;
    r = '0;
    v = value;
    for (int k = 0; k < 5; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // One conversion: returns edges from accept to bcd_valid and busy cycles.
  task automatic convert(input logic [15:0] v, output int edges, output int busy_cnt);
    int n;
    @(negedge clock_100Mhz);
    check("ready_before_accept", {31'd0, in_ready}, 32'd1);
    bin_in   = v;
    in_valid = 1'b1;
    @(negedge clock_100Mhz);
    in_valid = 1'b0;
    n        = 1;
    busy_cnt = busy ? 1 : 0;
    while (!bcd_valid && n < 40) begin
      @(negedge clock_100Mhz);
      n++;
      if (busy) busy_cnt++;
      if (n == 8) check("hold_during_conv", {12'd0, bcd_out}, {12'd0, last_bcd});
    end
    edges = bcd_valid ? n - 1 : -1;
    if (bcd_valid) check("busy_low_on_valid", {31'd0, busy}, 32'd0);
    if (bcd_valid) check("ready_on_valid", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int edges, bcnt, n, seen;
    logic [15:0] vals [0:19];

    n_cmp    = 0;
    n_fail   = 0;
    last_bcd = 20'h0;
    reset    = 1'b1;
    in_valid = 1'b0;
    bin_in   = 16'd0;

    // Reset state
    repeat (3) @(negedge clock_100Mhz);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_bcd_out", {12'd0, bcd_out}, 32'd0);
    check("rst_bcd_valid", {31'd0, bcd_valid}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    reset = 1'b0;
    $display("reset released");

    // 1: zero, latency and busy duration
    convert(16'd0, edges, bcnt);
    check("t1_latency", edges, 16);
    check("t1_busy_cycles", bcnt, 16);
    check("t1_bcd", {12'd0, bcd_out}, 32'h00000);
    check("t1_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clock_100Mhz);
    check("t1_valid_one_cycle", {31'd0, bcd_valid}, 32'd0);
    last_bcd = 20'h00000;
    $display("txn bin=0 bcd=%05h ovf=%0d lat=%0d", bcd_out, overflow, edges);

    // 2: display threshold
    convert(16'd9999, edges, bcnt);
    check("t2_9999_bcd", {12'd0, bcd_out}, 32'h09999);
    check("t2_9999_ovf", {31'd0, overflow}, 32'd0);
    last_bcd = 20'h09999;
    $display("txn bin=9999 bcd=%05h ovf=%0d", bcd_out, overflow);
    convert(16'd10000, edges, bcnt);
    check("t2_10000_bcd", {12'd0, bcd_out}, 32'h10000);
    check("t2_10000_ovf", {31'd0, overflow}, 32'd1);
    last_bcd = 20'h10000;
    $display("txn bin=10000 bcd=%05h ovf=%0d", bcd_out, overflow);

    // 3: full-scale and typical value
    convert(16'd65535, edges, bcnt);
    check("t3_65535_bcd", {12'd0, bcd_out}, 32'h65535);
    check("t3_65535_ovf", {31'd0, overflow}, 32'd1);
    last_bcd = 20'h65535;
    $display("txn bin=65535 bcd=%05h ovf=%0d", bcd_out, overflow);
    convert(16'd1234, edges, bcnt);
    check("t3_1234_bcd", {12'd0, bcd_out}, 32'h01234);
    check("t3_1234_ovf", {31'd0, overflow}, 32'd0);
    check("t3_1234_lat", edges, 16);
    last_bcd = 20'h01234;
    $display("txn bin=1234 bcd=%05h ovf=%0d", bcd_out, overflow);

    // 4: held in_valid, input changes mid-conversion, back-to-back spacing
    @(negedge clock_100Mhz);
    bin_in   = 16'd1234;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clock_100Mhz);
      n++;
      if (n == 3) bin_in = 16'd5678;
    end while (!bcd_valid && n < 40);
    check("t4_first_lat", n - 1, 16);
    check("t4_first_bcd", {12'd0, bcd_out}, 32'h01234);
    $display("txn bin=1234(held) bcd=%05h ovf=%0d", bcd_out, overflow);
    n = 0;
    do begin
      @(negedge clock_100Mhz);
      n++;
    end while (!bcd_valid && n < 60);
    in_valid = 1'b0;
    check("t4_spacing", n, 17);
    check("t4_second_bcd", {12'd0, bcd_out}, 32'h05678);
    check("t4_second_ovf", {31'd0, overflow}, 32'd0);
    last_bcd = 20'h05678;
    $display("txn bin=5678(held) bcd=%05h ovf=%0d spacing=%0d", bcd_out, overflow, n);

    // 5: reset in the middle of a conversion
    @(negedge clock_100Mhz);
    bin_in   = 16'd4321;
    in_valid = 1'b1;
    @(negedge clock_100Mhz);
    in_valid = 1'b0;
    repeat (7) @(negedge clock_100Mhz);
    @(posedge clock_100Mhz);
    #1 reset = 1'b1;
    #1;
    check("t5_async_busy", {31'd0, busy}, 32'd0);
    check("t5_async_bcd", {12'd0, bcd_out}, 32'd0);
    repeat (2) @(posedge clock_100Mhz);
    @(negedge clock_100Mhz);
    reset = 1'b0;
    @(negedge clock_100Mhz);
    check("t5_ready_after", {31'd0, in_ready}, 32'd1);
    check("t5_bcd_after", {12'd0, bcd_out}, 32'd0);
    check("t5_ovf_after", {31'd0, overflow}, 32'd0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock_100Mhz);
      if (bcd_valid) seen++;
    end
    check("t5_no_valid", seen, 0);
    last_bcd = 20'h00000;
    convert(16'd42, edges, bcnt);
    check("t5_42_bcd", {12'd0, bcd_out}, 32'h00042);
    check("t5_42_ovf", {31'd0, overflow}, 32'd0);
    last_bcd = 20'h00042;
    $display("txn bin=42 (after reset) bcd=%05h ovf=%0d", bcd_out, overflow);

    // 6: back-to-back values against the divide/modulo model
    vals[0] = 16'd9999;
    vals[1] = 16'd10000;
    vals[2] = 16'd0;
    vals[3] = 16'd65535;
    for (int i = 4; i < 20; i++) vals[i] = 16'($urandom_range(0, 65535));
    @(negedge clock_100Mhz);
    bin_in   = vals[0];
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      n = 0;
      do begin
        @(negedge clock_100Mhz);
        n++;
      end while (!bcd_valid && n < 60);
      check("t6_valid_seen", {31'd0, bcd_valid}, 32'd1);
      check("t6_bcd", {12'd0, bcd_out}, {12'd0, to_bcd(int'(vals[i]))});
      check("t6_ovf", {31'd0, overflow}, {31'd0, (vals[i] > 16'd9999)});
      $display("txn bin=%0d bcd=%05h ovf=%0d", vals[i], bcd_out, overflow);
      if (i < 19) bin_in = vals[i+1];
      else in_valid = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
